dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the core MEM stage and one external requester (UART loader / debug DMA).
- Sits between the core memory outputs (mem_en/mem_wea/mem_rea/mem_addr/mem_din) and the memory controller.
- Owns mem_hold: asserting it freezes the core pipeline while the external requester holds the port.
- Core has priority. The external side gets idle core cycles, or a forced window after a starvation limit.

Parameters:
- STARVE_LIM, 8: consecutive cycles ext_req may wait while the core is busy before the port is forcibly taken.
- MAX_BURST, 16: maximum consecutive external grants per ownership window.
- CNT_W, 5: width of the starvation and burst counters; must hold max(STARVE_LIM, MAX_BURST).

Ports:
- clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- core_en  in  4  core byte enables
- core_wea  in  1  core write
- core_rea  in  1  core read
- core_addr  in  32  core address
- core_din  in  32  core write data
- core_dout  out  32  read data to core
- mem_hold  out  1  pipeline stall to core
- ext_req  in  1  external request, held until granted
- ext_wea  in  1  external write (0 = read)
- ext_be  in  4  external byte enables
- ext_addr  in  32  external address
- ext_din  in  32  external write data
- ext_gnt  out  1  external access performed this cycle
- ext_rvalid  out  1  external read data valid
- ext_dout  out  32  external read data
- mem_en  out  4  to memory
- mem_wea  out  1  to memory
- mem_rea  out  1  to memory
- mem_addr  out  32  to memory
- mem_din  out  32  to memory
- mem_dout  in  32  from memory, 1-cycle read latency

Behaviour:
- Clock and reset: one clock, clk. Reset Rst is synchronous and active-high.
- core_busy = core_wea | core_rea | (core_en != 0).
- States:
  - CORE: memory port muxed to core.
  - EXT: memory port muxed to external requester.
  - DRAIN: memory idle.
- The state is registered. mem_hold = (state != CORE), decoded from the state register only, never from inputs.
- CORE state:
  - Core signals pass combinationally to the memory.
  - ext_gnt = 0.
  - If ext_req & !core_busy, go to EXT at the next edge.
  - If ext_req & core_busy, starve_cnt increments. When starve_cnt == STARVE_LIM-1 with ext_req still high, go to EXT regardless of core_busy.
  - starve_cnt clears whenever ext_req = 0 or on leaving CORE.
- EXT state:
  - mem_* = ext_* when ext_req, with mem_rea = ext_req & !ext_wea. Otherwise all mem_en/mem_wea/mem_rea = 0.
  - ext_gnt = ext_req (combinational). Each granted cycle is one completed access.
  - burst_cnt increments per grant.
  - Go to DRAIN when ext_req = 0, or when a grant occurs with burst_cnt == MAX_BURST-1.
- DRAIN state:
  - One cycle, memory idle, mem_hold still 1.
  - Lets the final external read return.
  - Then CORE; burst_cnt clears.
- Core request presented during EXT/DRAIN is not issued. The frozen core re-presents it in the first CORE cycle. Because the stall holds the request stable, it is issued exactly once.
- ext_rvalid: registered, = 1 in the cycle after a granted external read. ext_dout = mem_dout (valid only with ext_rvalid).
- core_dout = mem_dout unconditionally. The core only samples it after its own reads.
- Simultaneous events:
  - ext_req rising in the same cycle the core goes idle: the transition to EXT occurs at that edge. No core access is lost, because the idle cycle carries none.
  - Starvation limit and ext_req falling in the same cycle: stay in CORE.
- Reset values: state = CORE, starve_cnt = 0, burst_cnt = 0, ext_rvalid = 0, mem_hold = 0. ext_gnt = 0 and ext_dout don't-care.
- Rst in EXT or DRAIN aborts the window. A pending ext_rvalid is dropped, and the requester must re-issue.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t enum {CORE, EXT, DRAIN}
  - mem_req_t struct {en[3:0], wea, rea, addr[31:0], din[31:0]}
  - MEM_IDLE constant of type mem_req_t
- One sub-module, dmem_req_mux: combinational select of core / ext / idle mem_req_t by state.

Test Plan:
- Reset with ext_req = 1 → mem_hold = 0, ext_gnt = 0, ext_rvalid = 0. The first post-reset cycle passes the core request (addr 0x100, wea = 1) to mem_*.
- Core idle; ext write 0xDEADBEEF to 0x40 → next cycle EXT, mem_hold = 1, ext_gnt = 1, mem_addr = 0x40, mem_wea = 1. ext_req drops → DRAIN → CORE; mem_hold low after exactly 2 cycles.
- Core busy every cycle, ext_req = 1 held → forced EXT after 8 cycles. Stalled core store to 0x80 is issued exactly once after DRAIN; memory readback matches.
- 20-beat external read burst → 16 grants, DRAIN, CORE for at least 1 cycle, then remaining 4 grants. ext_rvalid follows each read grant by 1 cycle with correct data.
- Rst asserted mid-burst after an ext read grant → next cycle state CORE, mem_hold = 0, ext_rvalid = 0, counters 0.
- ext_req rising in the core's first idle cycle → grant next cycle. Core load issued the previous cycle returns the correct core_dout.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
//   arb_state_t : ownership state of the memory port
//   mem_req_t   : one memory-port request (byte enables, write, read, address, write data)
//   MEM_IDLE    : request value that performs no access
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CORE  = 2'd0,
    EXT   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [3:0]  en;
    logic        wea;
    logic        rea;
    logic [31:0] addr;
    logic [31:0] din;
  } mem_req_t;

  localparam mem_req_t MEM_IDLE = '{en: 4'h0, wea: 1'b0, rea: 1'b0, addr: 32'h0, din: 32'h0};

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of every bus signal around the data-memory port arbiter.
//   core_* : core MEM-stage request, read data and pipeline stall
//   ext_*  : external requester (loader / debug DMA) handshake and data
//   mem_*  : memory controller port (1-cycle read latency on mem_dout)
// slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_port_arbiter_if;
  logic [3:0]  core_en;
  logic        core_wea;
  logic        core_rea;
  logic [31:0] core_addr;
  logic [31:0] core_din;
  logic [31:0] core_dout;
  logic        mem_hold;

  logic        ext_req;
  logic        ext_wea;
  logic [3:0]  ext_be;
  logic [31:0] ext_addr;
  logic [31:0] ext_din;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_dout;

  logic [3:0]  mem_en;
  logic        mem_wea;
  logic        mem_rea;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  core_en, core_wea, core_rea, core_addr, core_din,
    output core_dout, mem_hold,
    input  ext_req, ext_wea, ext_be, ext_addr, ext_din,
    output ext_gnt, ext_rvalid, ext_dout,
    output mem_en, mem_wea, mem_rea, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output core_en, core_wea, core_rea, core_addr, core_din,
    input  core_dout, mem_hold,
    output ext_req, ext_wea, ext_be, ext_addr, ext_din,
    input  ext_gnt, ext_rvalid, ext_dout,
    input  mem_en, mem_wea, mem_rea, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_req_mux.sv
// Combinational memory-port request select.
//   state_i     : current port owner
//   core_req_i  : core request, passed through in CORE
//   ext_valid_i : external request present (ext_req)
//   ext_req_i   : external request, passed through in EXT while ext_valid_i
//   mem_req_o   : request presented to the memory controller (MEM_IDLE otherwise)
module dmem_req_mux
  import dmem_arb_pkg::*;
(
  input  arb_state_t state_i,
  input  mem_req_t   core_req_i,
  input  logic       ext_valid_i,
  input  mem_req_t   ext_req_i,
  output mem_req_t   mem_req_o
);

  always_comb begin
    mem_req_o = MEM_IDLE;
    unique case (state_i)
      CORE:    mem_req_o = core_req_i;
      EXT:     if (ext_valid_i) mem_req_o = ext_req_i;
      DRAIN:   mem_req_o = MEM_IDLE;
      default: mem_req_o = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the core MEM stage and one external requester.
// The core has priority; the external side takes idle core cycles, or a forced window once it
// has waited STARVE_LIM busy cycles. A window is at most MAX_BURST grants and is always closed
// by one DRAIN cycle so the final external read can return before the core resumes.
//   clk  : system clock
//   Rst  : synchronous active-high reset
//   bus  : core / external / memory signals (see dmem_port_arbiter_if)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 Rst,
  dmem_port_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] StarveLast = CNT_W'(STARVE_LIM - 1);
  localparam logic [CNT_W-1:0] BurstLast  = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             ext_rvalid_q, ext_rvalid_d;
  logic             ext_gnt;
  logic             core_busy;

  mem_req_t core_req, ext_mreq, mem_req;

  assign core_busy = bus.core_wea | bus.core_rea | (bus.core_en != 4'h0);

  assign core_req = '{en: bus.core_en, wea: bus.core_wea, rea: bus.core_rea,
                      addr: bus.core_addr, din: bus.core_din};
  assign ext_mreq = '{en: bus.ext_be, wea: bus.ext_wea, rea: ~bus.ext_wea,
                      addr: bus.ext_addr, din: bus.ext_din};

  dmem_req_mux u_req_mux (
    .state_i     (state_q),
    .core_req_i  (core_req),
    .ext_valid_i (bus.ext_req),
    .ext_req_i   (ext_mreq),
    .mem_req_o   (mem_req)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    ext_rvalid_d = 1'b0;
    ext_gnt      = 1'b0;
    unique case (state_q)
      CORE: begin
        if (!bus.ext_req) begin
          starve_cnt_d = '0;
        end else if (!core_busy || (starve_cnt_q == StarveLast)) begin
          // Idle core cycle, or the requester has waited long enough: take the port.
          state_d      = EXT;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      EXT: begin
        ext_gnt = bus.ext_req;
        if (bus.ext_req) begin
          burst_cnt_d  = burst_cnt_q + CNT_W'(1);
          ext_rvalid_d = ~bus.ext_wea;
          if (burst_cnt_q == BurstLast) state_d = DRAIN;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d     = CORE;
        burst_cnt_d = '0;
      end
      default: begin
        state_d      = CORE;
        starve_cnt_d = '0;
        burst_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q      <= CORE;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  // Stall decoded from the state register only, so it never depends on same-cycle inputs.
  assign bus.mem_hold   = (state_q != CORE);
  assign bus.ext_gnt    = ext_gnt;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_dout   = bus.mem_dout;
  assign bus.core_dout  = bus.mem_dout;

  assign bus.mem_en   = mem_req.en;
  assign bus.mem_wea  = mem_req.wea;
  assign bus.mem_rea  = mem_req.rea;
  assign bus.mem_addr = mem_req.addr;
  assign bus.mem_din  = mem_req.din;

endmodule
